// File: rtl/l2_wb_burst_serializer.sv
`default_nettype none
// ============================================================================
// Module   : l2_wb_burst_serializer
// Purpose  : Takes one dirty L2 line from the write buffer and writes it to
//            memory as a single AXI3 INCR burst of N = 1<<offset_width 32-bit
//            beats. It issues one AW, then N W beats, then waits for B and
//            reports the response status as a one-cycle done/err pulse.
// Ports    : clk, rstn (async, active-high despite the name)
//            line_valid/line_ready/line_addr/line_data : write-buffer side
//            done/err                                  : completion pulse
//            aw*/w*/b*                                 : AXI3 write channels
// Revision : 1.0 - initial release
// ============================================================================
module l2_wb_burst_serializer #(
  parameter int          offset_width = 2,
  parameter logic [3:0]  axi_id       = 4'h1
) (
  input  logic                          clk,
  input  logic                          rstn,
  // write-buffer side
  input  logic                          line_valid,
  output logic                          line_ready,
  input  logic [31:0]                   line_addr,
  input  logic [32*(1<<offset_width)-1:0] line_data,
  output logic                          done,
  output logic                          err,
  // AXI AW channel
  output logic [3:0]                    awid,
  output logic [31:0]                   awaddr,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic                          awvalid,
  input  logic                          awready,
  // AXI W channel
  output logic [3:0]                    wid,
  output logic [31:0]                   wdata,
  output logic [3:0]                    wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  // AXI B channel
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready
);

  localparam int                       c_beats     = 1 << offset_width;
  localparam logic [offset_width-1:0]  c_last_beat = offset_width'(c_beats - 1);
  // Byte-offset bits within a line: word offset plus the 2 byte-in-word bits.
  localparam logic [31:0]              c_offset_mask =
    32'((64'd1 << (offset_width + 2)) - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                        r_state;
  logic [31:0]                   r_addr;
  logic [32*c_beats-1:0]         r_data;
  logic [offset_width-1:0]       r_beat;
  logic [offset_width-1:0]       w_beat_next;
  // Only bresp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  logic                          w_bresp_unused;

  assign w_beat_next    = r_beat + 1'b1;
  assign w_bresp_unused = bresp[0];

  // Constant AW/W attributes: one full-line INCR burst of 32-bit words.
  assign awid    = axi_id;
  assign awaddr  = r_addr;
  assign awlen   = 8'(c_beats - 1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wid     = axi_id;
  assign wstrb   = 4'hF;
  // Beat counter only moves on a W handshake, so wdata holds under stall.
  assign wdata   = r_data[32*r_beat +: 32];

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_beat     <= '0;
      line_ready <= 1'b1;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      wlast      <= 1'b0;
      bready     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // done/err are single-cycle pulses unless set below.
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // line_ready is 1 throughout IDLE, so line_valid alone is the handshake.
          if (line_valid) begin
            r_addr     <= line_addr & ~c_offset_mask;
            r_data     <= line_data;
            line_ready <= 1'b0;
            awvalid    <= 1'b1;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            r_beat  <= '0;
            wlast   <= (c_last_beat == '0);
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (wready) begin
            if (wlast) begin
              wvalid  <= 1'b0;
              wlast   <= 1'b0;
              bready  <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_beat <= w_beat_next;
              // wlast is registered, so look one beat ahead.
              wlast  <= (w_beat_next == c_last_beat);
            end
          end
        end
        S_RESP: begin
          if (bvalid) begin
            bready     <= 1'b0;
            line_ready <= 1'b1;
            done       <= 1'b1;
            err        <= bresp[1];
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          line_ready <= 1'b1;
          awvalid    <= 1'b0;
          wvalid     <= 1'b0;
          wlast      <= 1'b0;
          bready     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_wb_burst_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_wb_burst_serializer
// Purpose  : Directed and randomized self-checking bench for
//            l2_wb_burst_serializer (N = 4). Inputs change and outputs are
//            sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_wb_burst_serializer;

  localparam int OFFW  = 2;
  localparam int NB    = 1 << OFFW;
  localparam int LINEB = 4 * NB;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          line_valid = 1'b0;
  logic          line_ready;
  logic [31:0]   line_addr = '0;
  logic [127:0]  line_data = '0;
  logic          done, err;
  logic [3:0]    awid;
  logic [31:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [3:0]    wid;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wlast, wvalid;
  logic          wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;

  int checks = 0;
  int errors = 0;

  l2_wb_burst_serializer #(.offset_width(OFFW), .axi_id(4'h1)) dut (
    .clk(clk), .rstn(rstn),
    .line_valid(line_valid), .line_ready(line_ready),
    .line_addr(line_addr), .line_data(line_data),
    .done(done), .err(err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a line is written as one burst starting at the line-aligned
  // address, words in ascending order, status error iff bresp >= 2.
  function automatic logic [31:0] ref_aligned(input logic [31:0] a);
    return a - (a % LINEB);
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".line_ready"}, line_ready, 1);
    chk({tag, ".awvalid"},    awvalid,    0);
    chk({tag, ".wvalid"},     wvalid,     0);
    chk({tag, ".bready"},     bready,     0);
    chk({tag, ".done"},       done,       0);
  endtask

  // Drives one line through the DUT with the given slave wait states and
  // checks every cycle against the reference. Starts in a cycle where the
  // DUT is expected to be ready (IDLE or the done cycle of the last line).
  task automatic run_line(input string tag, input logic [31:0] addr,
                          input logic [127:0] data, input int aw_wait,
                          input logic [3:0][3:0] w_wait, input int b_wait,
                          input logic [1:0] resp);
    logic [31:0] exp_addr;
    logic        exp_err;
    logic [31:0] exp_word;
    exp_addr = ref_aligned(addr);
    exp_err  = (resp >= 2'd2);

    chk({tag, ".line_ready"}, line_ready, 1);
    line_valid = 1'b1;
    line_addr  = addr;
    line_data  = data;
    @(negedge clk);
    // Scramble the request inputs to prove the line was latched.
    line_valid = 1'b0;
    line_addr  = $urandom;
    line_data  = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, ".done_pulse_end"}, done, 0);
    chk({tag, ".line_ready_busy"}, line_ready, 0);
    chk({tag, ".awlen"}, awlen, NB - 1);
    chk({tag, ".awsize"}, awsize, 3'b010);
    chk({tag, ".awburst"}, awburst, 2'b01);
    chk({tag, ".awid"}, awid, 4'h1);

    for (int k = 0; k <= aw_wait; k++) begin
      chk($sformatf("%s.awvalid[%0d]", tag, k), awvalid, 1);
      chk($sformatf("%s.awaddr[%0d]", tag, k), awaddr, exp_addr);
      chk($sformatf("%s.wvalid_pre_aw[%0d]", tag, k), wvalid, 0);
      awready = (k == aw_wait);
      wready  = $urandom_range(0, 1);
      @(negedge clk);
    end
    awready = 1'b0;

    for (int i = 0; i < NB; i++) begin
      exp_word = data[32*i +: 32];
      for (int k = 0; k <= int'(w_wait[i]); k++) begin
        chk($sformatf("%s.wvalid[%0d.%0d]", tag, i, k), wvalid, 1);
        chk($sformatf("%s.awvalid_off[%0d.%0d]", tag, i, k), awvalid, 0);
        chk($sformatf("%s.wdata[%0d.%0d]", tag, i, k), wdata, exp_word);
        chk($sformatf("%s.wlast[%0d.%0d]", tag, i, k), wlast, (i == NB - 1));
        chk($sformatf("%s.wstrb[%0d]", tag, i), wstrb, 4'hF);
        chk($sformatf("%s.wid[%0d]", tag, i), wid, 4'h1);
        wready  = (k == int'(w_wait[i]));
        awready = $urandom_range(0, 1);
        bvalid  = $urandom_range(0, 1);
        @(negedge clk);
      end
    end
    wready  = 1'b0;
    awready = 1'b0;
    bvalid  = 1'b0;

    for (int k = 0; k <= b_wait; k++) begin
      chk($sformatf("%s.bready[%0d]", tag, k), bready, 1);
      chk($sformatf("%s.wvalid_resp[%0d]", tag, k), wvalid, 0);
      chk($sformatf("%s.done_early[%0d]", tag, k), done, 0);
      bvalid = (k == b_wait);
      bresp  = (k == b_wait) ? resp : 2'($urandom);
      wready = $urandom_range(0, 1);
      @(negedge clk);
    end
    bvalid = 1'b0;
    wready = 1'b0;

    chk({tag, ".done"}, done, 1);
    chk({tag, ".err"}, err, exp_err);
    chk({tag, ".line_ready_done"}, line_ready, 1);
    chk({tag, ".bready_off"}, bready, 0);
  endtask

  initial begin
    logic [3:0][3:0] no_wait;
    logic [3:0][3:0] ww;
    no_wait = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset.wlast", wlast, 0);
    chk("reset.err", err, 0);
    chk("reset.awaddr", awaddr, 0);
    chk("reset.wdata", wdata, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // Basic zero-wait line; followed immediately by a back-to-back line
    run_line("basic", 32'h1C00_0014, 128'h00000044_00000033_00000022_00000011,
             0, no_wait, 0, 2'b00);

    // wready low 3 cycles on beat 2 (accepted in the done cycle above)
    ww = '0;
    ww[2] = 4'd3;
    run_line("wstall", 32'h2000_00A8, 128'h00000044_00000033_00000022_00000011,
             0, ww, 0, 2'b00);

    // SLVERR response, then a line accepted in the done cycle
    run_line("slverr", 32'h3000_0100, 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001,
             0, no_wait, 1, 2'b10);
    run_line("b2b", 32'h3000_011F, 128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001,
             0, no_wait, 0, 2'b11);

    // awready delayed 5 cycles
    run_line("awstall", 32'h4000_0037, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1,
             5, no_wait, 0, 2'b01);

    // Spurious channel inputs while idle must do nothing
    @(negedge clk);
    chk("idle.done_cleared", done, 0);
    bvalid = 1'b1; bresp = 2'b10; awready = 1'b1; wready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle_outputs($sformatf("spurious[%0d]", k));
      chk($sformatf("spurious[%0d].err", k), err, 0);
    end
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0; bresp = 2'b00;

    // Reset pulsed during beat 1
    line_valid = 1'b1;
    line_addr  = 32'h5000_0044;
    line_data  = 128'h00000044_00000033_00000022_00000011;
    @(negedge clk);
    line_valid = 1'b0;
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    chk("rstmid.beat0", wdata, 32'h11);
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    chk("rstmid.beat1", wdata, 32'h22);
    rstn = 1'b1;
    #1;
    chk_idle_outputs("rstmid.async");
    chk("rstmid.wlast", wlast, 0);
    chk("rstmid.err", err, 0);
    chk("rstmid.awaddr", awaddr, 0);
    chk("rstmid.wdata", wdata, 0);
    @(negedge clk);
    rstn = 1'b0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle_outputs($sformatf("rstmid.after[%0d]", k));
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    run_line("rstmid.next", 32'h5000_0080, 128'h0000BBBB_0000AAAA_00009999_00008888,
             0, no_wait, 0, 2'b00);

    // Randomized lines with random slave timing and responses
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NB; i++) ww[i] = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_line($sformatf("rand%0d", n), $urandom,
               {$urandom, $urandom, $urandom, $urandom},
               int'($urandom_range(0, 3)), ww, int'($urandom_range(0, 3)),
               2'($urandom));
    end

    @(negedge clk);
    chk("final.done_cleared", done, 0);
    chk("final.err_cleared", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_wb_burst_serializer.md
L2_WB_BURST_SERIALIZER -- requirements
Module: l2_wb_burst_serializer

Interface
REQ-001 SHALL have parameter offset_width, default 2; N = 1<<offset_width 32-bit beats per line.
REQ-002 SHALL have parameter axi_id, default 4'h1; this is the constant AXI write ID.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rstn  in  1  asynchronous reset, active-high (1 = reset).
REQ-006 line_valid  in  1  dirty-line write request from the write buffer.
REQ-007 line_ready  out  1  block can accept a line.
REQ-008 line_addr  in  32  line address.
REQ-009 line_data  in  32*N  line data; word i = bits [32i+31:32i].
REQ-010 done  out  1  one-cycle pulse when the write response is received.
REQ-011 err  out  1  response status; valid while done=1.
REQ-012 awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI AW channel.
REQ-013 awready  in  1  AXI AW channel ready.
REQ-014 wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI W channel.
REQ-015 wready  in  1  AXI W channel ready.
REQ-016 bresp  in  2  AXI B channel response; bvalid  in  1; bready  out  1.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, DATA, RESP; the reset state is IDLE.
REQ-018 line_ready SHALL be 1 only in IDLE; the other state outputs are:
- ADDR: awvalid=1.
- DATA: wvalid=1.
- RESP: bready=1.
- All three outputs are 0 in every other state.
REQ-019 On line_valid&&line_ready the block SHALL:
- latch line_data;
- latch line_addr with bits [offset_width+1:0] forced to 0;
- go to ADDR.
REQ-020 awaddr SHALL equal the latched aligned address and remain stable until the AW handshake.
REQ-021 AW fields SHALL be: awlen=N-1, awsize=3'b010, awburst=2'b01 (INCR), awid=axi_id.
REQ-022 ADDR SHALL go to DATA on awvalid&&awready, with the beat counter cleared to 0; wvalid SHALL NOT assert before the AW handshake completes.
REQ-023 In DATA, the W channel SHALL drive:
- wdata = latched word[beat];
- wstrb = 4'hF;
- wid = axi_id;
- wlast = 1 only when beat == N-1.
REQ-024 On wvalid&&wready in DATA:
- if wlast=1, go to RESP;
- otherwise increment beat.
- wdata SHALL hold while wready=0.
REQ-025 The beat counter SHALL be offset_width bits wide and SHALL NOT wrap within a burst.
REQ-026 In RESP, on bvalid&&bready:
- go to IDLE;
- register done=1 for exactly the next cycle;
- register err = bresp[1] (SLVERR/DECERR) into that same cycle.
- done, err SHALL be 0 at all other times.
REQ-027 A new line SHALL be accepted in the same cycle done is high (back-to-back); throughput is one line per N+3 cycles minimum with zero-wait slaves.
REQ-028 bvalid outside RESP, and awready/wready outside their states, SHALL be ignored with no state change.
REQ-029 AW-to-W and W-to-B latency SHALL be 1 cycle minimum.

Reset
REQ-030 Reset values SHALL be:
- state=IDLE, line_ready=1, beat=0;
- awvalid=wvalid=bready=wlast=0;
- done=err=0;
- latched address and data = 0.
REQ-031 Reset asserted mid-burst SHALL abort immediately, with no further beats or handshakes after release.

Verification
REQ-032 N=4, addr 0x1C00_0014, data words 0x11,0x22,0x33,0x44, slave with zero waits:
- expect awaddr=0x1C00_0010 and awlen=3;
- expect wdata sequence 0x11..0x44 with wlast on the 4th beat;
- bresp=0 -> done=1 and err=0, one cycle.
REQ-033 wready low for 3 cycles on beat 2 -> wdata=0x33 held stable, no beat skipped or duplicated.
REQ-034 bresp=2'b10 -> done=1 with err=1; next line accepted in the done cycle.
REQ-035 awready delayed 5 cycles -> awvalid and awaddr stable, wvalid=0 throughout.
REQ-036 rstn pulsed high during beat 1 -> all outputs at reset values; next line completes a full 4-beat burst normally.
REQ-037 Spurious bvalid in IDLE -> no done, state unchanged.
